// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU adder blocks.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    ADD_OP = 1'b0,
    SUB_OP = 1'b1
  } add_mode_e;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
  } add_flags_t;

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for the pipelined adder.
// master drives operands and accepts results, slave is the adder itself.
interface pipe_adder_if
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, op1, op2, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, op1, op2, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, zero
  );

endinterface

// File: rtl/adder_slice.sv
// adder_slice: combinational SLICE-bit adder with carry in/out.
// Also exposes the carry into its top bit so the most significant slice
// can produce the signed-overflow flag.
module adder_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] i_a,
  input  logic [SLICE-1:0] i_b,
  input  logic             i_cin,
  output logic [SLICE-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [SLICE:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SLICE{1'b0}}, i_cin};
  assign o_sum  = w_full[SLICE-1:0];
  assign o_cout = w_full[SLICE];
  // Top sum bit is a ^ b ^ c there, so the incoming carry falls out by XOR.
  assign o_cmsb = w_full[SLICE-1] ^ i_a[SLICE-1] ^ i_b[SLICE-1];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract with the carry chain split into STAGES
// slices, one slice resolved per cycle. Fixed latency of STAGES cycles,
// one item per cycle, whole pipe stalls on output backpressure.
module pipe_adder
  import alu_pkg::*;
#(
  parameter int WIDTH  = XLEN,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);

  localparam int SLICE = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << SLICE) - WIDTH'(1);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $fatal(1, "pipe_adder: WIDTH=%0d must be a multiple of STAGES=%0d", WIDTH, STAGES);
  end

  add_mode_e        w_mode;
  logic             w_en;
  logic             w_v_in    [STAGES];
  logic [WIDTH-1:0] w_a_in    [STAGES];
  logic [WIDTH-1:0] w_b_in    [STAGES];
  logic             w_c_in    [STAGES];
  logic [SLICE-1:0] w_sum     [STAGES];
  logic             w_cout    [STAGES];
  logic             w_cmsb    [STAGES];
  logic [WIDTH-1:0] w_word_nx [STAGES];
  add_flags_t       w_flags;

  // r_word holds finished result slices below the current stage and the
  // untouched op1 slices above it, so one vector serves both purposes.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_word  [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_carry [STAGES];
  add_flags_t       r_flags;

  assign w_mode = add_mode_e'(bus.sub);
  assign w_en   = !r_valid[STAGES-1] || bus.out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam logic [WIDTH-1:0] SLICE_MASK = LOW_MASK << (gi * SLICE);

    if (gi == 0) begin : g_first
      assign w_v_in[gi] = bus.in_valid;
      assign w_a_in[gi] = bus.op1;
      assign w_b_in[gi] = (w_mode == SUB_OP) ? ~bus.op2 : bus.op2;
      assign w_c_in[gi] = (w_mode == SUB_OP);
    end else begin : g_next
      assign w_v_in[gi] = r_valid[gi-1];
      assign w_a_in[gi] = r_word[gi-1];
      assign w_b_in[gi] = r_b[gi-1];
      assign w_c_in[gi] = r_carry[gi-1];
    end

    adder_slice #(
      .SLICE(SLICE)
    ) u_slice (
      .i_a    (w_a_in[gi][gi*SLICE +: SLICE]),
      .i_b    (w_b_in[gi][gi*SLICE +: SLICE]),
      .i_cin  (w_c_in[gi]),
      .o_sum  (w_sum[gi]),
      .o_cout (w_cout[gi]),
      .o_cmsb (w_cmsb[gi])
    );

    // Replace the consumed op1 slice with its freshly computed sum slice.
    assign w_word_nx[gi] = (w_a_in[gi] & ~SLICE_MASK) | (WIDTH'(w_sum[gi]) << (gi * SLICE));
  end

  assign w_flags.carry    = w_cout[STAGES-1];
  assign w_flags.overflow = w_cmsb[STAGES-1] ^ w_cout[STAGES-1];
  assign w_flags.zero     = (w_word_nx[STAGES-1] == '0);

  // Whole pipe advances in lockstep when the output slot is free or draining.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_word[k]  <= '0;
        r_b[k]     <= '0;
        r_carry[k] <= 1'b0;
      end
      r_flags <= '0;
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_v_in[k];
        r_word[k]  <= w_word_nx[k];
        r_b[k]     <= w_b_in[k];
        r_carry[k] <= w_cout[k];
      end
      r_flags <= w_flags;
    end
  end

  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_valid[STAGES-1];
  assign bus.result    = r_word[STAGES-1];
  assign bus.carry_out = r_flags.carry;
  assign bus.overflow  = r_flags.overflow;
  assign bus.zero      = r_flags.zero;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder. Main instance 32/4 runs
// directed, streaming, backpressure and reset cases plus a random sweep;
// extra instances 32/1, 32/32 and 16/2 run random sweeps in parallel.
module tb_pipe_adder;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   check_cnt = 0;
  int   err_cnt   = 0;
  exp_t exp_q[$];

  logic [31:0] st_a [8] = '{32'h0000_0001, 32'hFFFF_0000, 32'h1234_5678, 32'h8000_0000,
                            32'h0000_FFFF, 32'hDEAD_BEEF, 32'h7FFF_FFFF, 32'h0000_0000};
  logic [31:0] st_b [8] = '{32'h0000_0002, 32'h0001_0000, 32'h1111_1111, 32'h8000_0000,
                            32'h0000_0001, 32'h0000_BEEF, 32'hFFFF_FFFF, 32'h0000_0001};
  logic        st_s [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  pipe_adder_if #(.WIDTH(32)) m_bus ();

  pipe_adder #(
    .WIDTH (32),
    .STAGES(4)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (m_bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic c, input logic v, input logic z);
    exp_t e;
    e.res = r; e.c = c; e.v = v; e.z = z;
    return e;
  endfunction

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic s);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] bb;
    logic [32:0] full;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am    = a & mask;
    bb    = (s ? ~b : b) & mask;
    full  = {1'b0, am} + {1'b0, bb} + {32'd0, s};
    e.res = full[31:0] & mask;
    e.c   = full[w];
    e.v   = (am[w-1] == bb[w-1]) && (e.res[w-1] != am[w-1]);
    e.z   = (e.res == 32'd0);
    return e;
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    int n = 0;
    m_bus.in_valid = 1'b1;
    m_bus.op1      = a;
    m_bus.op2      = b;
    m_bus.sub      = s;
    forever begin
      @(negedge clk);
      if (m_bus.in_ready) begin
        exp_q.push_back(e);
        break;
      end
      n++;
      if (n > 200) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic measure_latency(input string name);
    int edges = 1;
    forever begin
      @(negedge clk);
      if (m_bus.out_valid || edges > 50) break;
      @(posedge clk);
      edges++;
    end
    check(name, edges, 4);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Main scoreboard monitor: compare on every output transfer.
  always @(negedge clk) begin : main_mon
    exp_t e;
    if (rst_n && m_bus.out_valid && m_bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("main_unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("main_result",   m_bus.result,    e.res);
        check("main_carry",    m_bus.carry_out, e.c);
        check("main_overflow", m_bus.overflow,  e.v);
        check("main_zero",     m_bus.zero,      e.z);
        $display("[%0t] main out result=0x%08h c=%0b v=%0b z=%0b", $time, m_bus.result,
                 m_bus.carry_out, m_bus.overflow, m_bus.zero);
      end
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int W = (gi == 2) ? 16 : 32;
    localparam int S = (gi == 0) ? 1 : ((gi == 1) ? 32 : 2);

    pipe_adder_if #(.WIDTH(W)) c_bus ();
    logic c_rst_n;
    bit   done_flag;
    exp_t c_q[$];

    pipe_adder #(
      .WIDTH (W),
      .STAGES(S)
    ) u_dut (
      .clk  (clk),
      .rst_n(c_rst_n),
      .bus  (c_bus)
    );

    initial begin : ready_drv
      c_bus.out_ready = 1'b0;
      forever begin
        @(posedge clk); #2;
        c_bus.out_ready = 1'($urandom_range(0, 1));
      end
    end

    always @(negedge clk) begin : mon
      exp_t e;
      if (c_rst_n && c_bus.out_valid && c_bus.out_ready) begin
        if (c_q.size() == 0) begin
          check($sformatf("cfg%0d_unexpected_output", gi), 1, 0);
        end else begin
          e = c_q.pop_front();
          check($sformatf("cfg%0d_result", gi),   64'(c_bus.result), 64'(e.res));
          check($sformatf("cfg%0d_carry", gi),    c_bus.carry_out, e.c);
          check($sformatf("cfg%0d_overflow", gi), c_bus.overflow,  e.v);
          check($sformatf("cfg%0d_zero", gi),     c_bus.zero,      e.z);
          $display("[%0t] cfg%0d W=%0d S=%0d out result=0x%0h c=%0b v=%0b z=%0b", $time, gi,
                   W, S, c_bus.result, c_bus.carry_out, c_bus.overflow, c_bus.zero);
        end
      end
    end

    initial begin : stim
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      int          n;
      done_flag      = 1'b0;
      c_rst_n        = 1'b0;
      c_bus.in_valid = 1'b0;
      c_bus.op1      = '0;
      c_bus.op2      = '0;
      c_bus.sub      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check($sformatf("cfg%0d_rst_out_valid", gi), c_bus.out_valid, 0);
      @(posedge clk); #1;
      c_rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
        a = $urandom;
        b = $urandom;
        s = 1'($urandom_range(0, 1));
        c_bus.in_valid = 1'b1;
        c_bus.op1      = a[W-1:0];
        c_bus.op2      = b[W-1:0];
        c_bus.sub      = s;
        n = 0;
        forever begin
          @(negedge clk);
          if (c_bus.in_ready) begin
            c_q.push_back(model(W, a, b, s));
            break;
          end
          n++;
          if (n > 200) begin
            check($sformatf("cfg%0d_send_timeout", gi), 1, 0);
            break;
          end
        end
        @(posedge clk); #1;
      end
      c_bus.in_valid = 1'b0;
      n = 0;
      while (c_q.size() != 0 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("cfg%0d_drain", gi), c_q.size(), 0);
      done_flag = 1'b1;
    end
  end

  bit rand_done;

  initial begin : main_stim
    int n;
    m_bus.in_valid  = 1'b0;
    m_bus.op1       = '0;
    m_bus.op2       = '0;
    m_bus.sub       = 1'b0;
    m_bus.out_ready = 1'b1;
    rst_n           = 1'b0;
    rand_done       = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", m_bus.out_valid, 0);
    check("rst_result",    m_bus.result,    0);
    check("rst_carry",     m_bus.carry_out, 0);
    check("rst_overflow",  m_bus.overflow,  0);
    check("rst_zero",      m_bus.zero,      0);
    check("rst_in_ready",  m_bus.in_ready,  1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic add with latency measurement.
    send(32'h0000_0005, 32'h0000_0003, 1'b0, mk(32'h0000_0008, 1'b0, 1'b0, 1'b0));
    m_bus.in_valid = 1'b0;
    measure_latency("latency_basic");
    drain("drain_basic");

    // Flag corners, back to back.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    send(32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(32'h0000_0000, 32'h0000_0000, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1));
    m_bus.in_valid = 1'b0;
    drain("drain_corners");

    // Streaming with a 3-cycle output stall once results start flowing.
    fork
      begin
        for (int i = 0; i < 8; i++) send(st_a[i], st_b[i], st_s[i], model(32, st_a[i], st_b[i], st_s[i]));
        m_bus.in_valid = 1'b0;
      end
      begin
        exp_t held;
        int   w = 0;
        held = model(32, st_a[1], st_b[1], st_s[1]);
        while (!m_bus.out_valid && w < 100) begin
          @(negedge clk);
          w++;
        end
        @(posedge clk); #1;
        m_bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready",  m_bus.in_ready,  0);
          check("stall_out_valid", m_bus.out_valid, 1);
          check("stall_result",    m_bus.result,    held.res);
          @(posedge clk); #1;
        end
        m_bus.out_ready = 1'b1;
      end
    join
    drain("drain_stream");

    // Reset with three items in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) send(32'h100 + i, 32'h10, 1'b0, mk(32'h110 + i, 1'b0, 1'b0, 1'b0));
    m_bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", m_bus.out_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_mid_no_stale", m_bus.out_valid, 0);
    end
    @(posedge clk); #1;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, mk(32'h2345_6789, 1'b0, 1'b0, 1'b0));
    m_bus.in_valid = 1'b0;
    measure_latency("latency_after_reset");
    drain("drain_after_reset");

    // Random sweep with random downstream readiness.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #2;
          m_bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 100; i++) begin
          a = $urandom;
          b = $urandom;
          s = 1'($urandom_range(0, 1));
          send(a, b, s, model(32, a, b, s));
        end
        m_bus.in_valid = 1'b0;
        drain("drain_random");
        rand_done = 1'b1;
      end
    join
    m_bus.out_ready = 1'b1;

    n = 0;
    while (!(g_cfg[0].done_flag && g_cfg[1].done_flag && g_cfg[2].done_flag) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("cfg_sweeps_done", {g_cfg[0].done_flag, g_cfg[1].done_flag, g_cfg[2].done_flag}, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
